// File: rtl/sink_responder.sv
// rtl/sink_responder.sv - in-order scratchpad responder for the sink request/response interface
// Requests touch the scratchpad at accept time; results wait in a FIFO until their due cycle.
module sink_responder #(
  parameter int IDBITS     = 4,
  parameter int DATABITS   = 512,
  parameter int ADDRBITS   = 32,
  parameter int WORDS_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int QDEPTH     = 4
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                mvalid_i,
  output logic                mready_o,
  input  logic [IDBITS-1:0]   mid_i,
  input  logic [ADDRBITS-1:0] maddr_i,
  input  logic [DATABITS-1:0] mdata_i,
  input  logic                mrw_i,
  output logic                svalid_o,
  input  logic                sready_i,
  output logic [IDBITS-1:0]   sid_o,
  output logic [DATABITS-1:0] sdata_o,
  output logic [1:0]          sresp_o,
  output logic                srw_o
);

  localparam int OFS = $clog2(DATABITS/8);
  localparam int CW  = $clog2(LATENCY) + 2;
  localparam int PW  = $clog2(QDEPTH);
  localparam int NW  = PW + 1;
  localparam logic [ADDRBITS-1:0] LOW_MASK = ADDRBITS'((1 << OFS) - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_VALID = 1'b1;

  logic [DATABITS-1:0] mem [2**WORDS_LOG2];

  logic [IDBITS-1:0]   q_id   [QDEPTH];
  logic                q_rw   [QDEPTH];
  logic [1:0]          q_resp [QDEPTH];
  logic [DATABITS-1:0] q_data [QDEPTH];
  logic [CW-1:0]       q_due  [QDEPTH];
  logic [QDEPTH-1:0]   ripe_q;

  logic [0:0]          state_q, state_d;
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d, head_nxt, sel;
  logic [NW-1:0]       count_q, count_d;
  logic [CW-1:0]       cyc_q;
  logic                ready_en_q;
  logic [IDBITS-1:0]   sid_q, sid_d;
  logic [DATABITS-1:0] sdata_q, sdata_d;
  logic [1:0]          sresp_q, sresp_d;
  logic                srw_q, srw_d;
  logic                push, pop, load, addr_err, head_due, next_due;
  logic [WORDS_LOG2-1:0] idx;

  assign idx      = maddr_i[OFS +: WORDS_LOG2];
  assign addr_err = (|(maddr_i & LOW_MASK)) | (|(maddr_i >> (OFS + WORDS_LOG2)));
  assign mready_o = ready_en_q & (count_q != NW'(QDEPTH));
  assign push     = mvalid_i & mready_o;
  assign svalid_o = (state_q == S_VALID);
  assign pop      = svalid_o & sready_i;
  assign head_nxt = head_q + PW'(1);

  // ripe_q latches "due reached" so a long sready stall cannot let the counter lap an entry
  assign head_due = (count_q != '0) && (ripe_q[head_q] || (cyc_q == q_due[head_q]));
  assign next_due = (count_q >= NW'(2)) && (ripe_q[head_nxt] || (cyc_q == q_due[head_nxt]));

  assign sid_o   = sid_q;
  assign sdata_o = sdata_q;
  assign sresp_o = sresp_q;
  assign srw_o   = srw_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    sel     = head_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (head_due) begin
          load    = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (sready_i) begin
          head_d = head_nxt;
          sel    = head_nxt;
          if (next_due) load = 1'b1;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sid_d   = sid_q;
    sdata_d = sdata_q;
    sresp_d = sresp_q;
    srw_d   = srw_q;
    if (load) begin
      sid_d   = q_id[sel];
      sdata_d = q_data[sel];
      sresp_d = q_resp[sel];
      srw_d   = q_rw[sel];
    end

    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      ready_en_q <= 1'b0;
      ripe_q     <= '0;
      sid_q      <= '0;
      sdata_q    <= '0;
      sresp_q    <= '0;
      srw_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cyc_q      <= cyc_q + CW'(1);
      ready_en_q <= 1'b1;
      sid_q      <= sid_d;
      sdata_q    <= sdata_d;
      sresp_q    <= sresp_d;
      srw_q      <= srw_d;
      for (int i = 0; i < QDEPTH; i++) begin
        if (push && (tail_q == PW'(i))) ripe_q[i] <= 1'b0;
        else if (cyc_q == q_due[i])     ripe_q[i] <= 1'b1;
      end
    end
  end

  // Scratchpad and queue payload carry no reset; validity is tracked by count_q alone
  always_ff @(posedge clock_i) begin
    if (push) begin
      q_id[tail_q]   <= mid_i;
      q_rw[tail_q]   <= mrw_i;
      q_resp[tail_q] <= addr_err ? RESP_SLVERR : RESP_OKAY;
      q_data[tail_q] <= (mrw_i && !addr_err) ? mem[idx] : '0;
      q_due[tail_q]  <= cyc_q + CW'(LATENCY);
      if (!mrw_i && !addr_err) mem[idx] <= mdata_i;
    end
  end

endmodule
